muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the control path, register-file read/write ports
// and the iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
  parameter int W = 32
);
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] rs1_val;
  logic [W-1:0] rs2_val;
  logic [4:0]   rd_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [4:0]   rd_out;
  logic         RegWEn_out;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, result, rd_out, RegWEn_out
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, result, rd_out, RegWEn_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add / restoring divide, then sign fix.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the CALC phase.
module muldiv_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         AReset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  state_t         state_r, state_s;
  logic [5:0]     step_r;
  logic [2:0]     f3_r;
  logic [W-1:0]   a_r, b_r, hi_r, lo_r;
  logic [4:0]     rd_r;
  logic [W-1:0]   result_r;
  logic [4:0]     rd_out_r;
  logic           done_r, wen_r;

  logic           a_sgn_s, b_sgn_s, is_div_s, early_s;
  logic [W-1:0]   a_mag_s, b_mag_s;
  logic [W:0]     sum_s, shift_s, diff_s;
  logic [2*W-1:0] prod_fix_s;
  logic [W-1:0]   quo_fix_s, rem_fix_s, fix_result_s;
  logic           div0_s, ovf_s;

  function automatic logic sgn_a_f(input logic [2:0] f3);
    case (f3)
      3'b001, 3'b010, 3'b100, 3'b110: sgn_a_f = 1'b1;
      default:                        sgn_a_f = 1'b0;
    endcase
  endfunction

  function automatic logic sgn_b_f(input logic [2:0] f3);
    case (f3)
      3'b001, 3'b100, 3'b110: sgn_b_f = 1'b1;
      default:                sgn_b_f = 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] mag_f(input logic [W-1:0] v, input logic sgn);
    if (sgn && v[W-1]) mag_f = {W{1'b0}} - v;
    else               mag_f = v;
  endfunction

  assign a_sgn_s  = sgn_a_f(f3_r);
  assign b_sgn_s  = sgn_b_f(f3_r);
  assign is_div_s = f3_r[2];
  assign a_mag_s  = mag_f(a_r, a_sgn_s);
  assign b_mag_s  = mag_f(b_r, b_sgn_s);

  // One shift-add step keeps the 64-bit product in {hi_r, lo_r}, multiplier bits leaving lo_r.
  assign sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_mag_s} : {(W+1){1'b0}});
  // One restoring step: remainder in hi_r, quotient bits shifting into lo_r.
  assign shift_s = {hi_r, lo_r[W-1]};
  assign diff_s  = shift_s - {1'b0, b_mag_s};

`ifdef MULDIV_EARLY_OUT_EN
  assign early_s = bus.funct3[2] &
                   ((bus.rs2_val == {W{1'b0}}) |
                    (((bus.funct3 == 3'b100) | (bus.funct3 == 3'b110)) &
                     (bus.rs1_val == MIN_NEG) & (bus.rs2_val == {W{1'b1}})));
`else
  assign early_s = 1'b0;
`endif

  assign div0_s = is_div_s & (b_r == {W{1'b0}});
  assign ovf_s  = is_div_s & b_sgn_s & (a_r == MIN_NEG) & (b_r == {W{1'b1}});

  // Sign correction and result selection for the FIX cycle.
  always_comb begin
    prod_fix_s   = {hi_r, lo_r};
    quo_fix_s    = lo_r;
    rem_fix_s    = hi_r;
    fix_result_s = {W{1'b0}};
    if ((a_sgn_s & a_r[W-1]) ^ (b_sgn_s & b_r[W-1])) prod_fix_s = {(2*W){1'b0}} - {hi_r, lo_r};
    else                                              prod_fix_s = {hi_r, lo_r};
    if (b_sgn_s && (a_r[W-1] ^ b_r[W-1])) quo_fix_s = {W{1'b0}} - lo_r;
    else                                  quo_fix_s = lo_r;
    if (a_sgn_s && a_r[W-1]) rem_fix_s = {W{1'b0}} - hi_r;
    else                     rem_fix_s = hi_r;
    if (div0_s) begin
      if (f3_r[1]) fix_result_s = a_r;
      else         fix_result_s = {W{1'b1}};
    end else if (ovf_s) begin
      if (f3_r[1]) fix_result_s = {W{1'b0}};
      else         fix_result_s = MIN_NEG;
    end else begin
      case (f3_r)
        3'b000:                 fix_result_s = prod_fix_s[W-1:0];
        3'b001, 3'b010, 3'b011: fix_result_s = prod_fix_s[2*W-1:W];
        3'b100, 3'b101:         fix_result_s = quo_fix_s;
        3'b110, 3'b111:         fix_result_s = rem_fix_s;
        default:                fix_result_s = {W{1'b0}};
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge AReset) begin
    if (!AReset) state_r <= IDLE;
    else         state_r <= state_s;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = early_s ? FIX : CALC;
        else           state_s = IDLE;
      end
      CALC: begin
        if (step_r == 6'd31) state_s = FIX;
        else                 state_s = CALC;
      end
      FIX:     state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge AReset) begin
    if (!AReset) begin
      step_r   <= 6'd0;
      f3_r     <= 3'd0;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      hi_r     <= {W{1'b0}};
      lo_r     <= {W{1'b0}};
      rd_r     <= 5'd0;
      result_r <= {W{1'b0}};
      rd_out_r <= 5'd0;
      done_r   <= 1'b0;
      wen_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            f3_r   <= bus.funct3;
            a_r    <= bus.rs1_val;
            b_r    <= bus.rs2_val;
            rd_r   <= bus.rd_in;
            step_r <= 6'd0;
            hi_r   <= {W{1'b0}};
            lo_r   <= bus.funct3[2] ? mag_f(bus.rs1_val, sgn_a_f(bus.funct3))
                                    : mag_f(bus.rs2_val, sgn_b_f(bus.funct3));
          end
        end
        CALC: begin
          step_r <= step_r + 6'd1;
          if (is_div_s) begin
            if (!diff_s[W]) begin
              hi_r <= diff_s[W-1:0];
              lo_r <= {lo_r[W-2:0], 1'b1};
            end else begin
              hi_r <= shift_s[W-1:0];
              lo_r <= {lo_r[W-2:0], 1'b0};
            end
          end else begin
            hi_r <= sum_s[W:1];
            lo_r <= {sum_s[0], lo_r[W-1:1]};
          end
        end
        FIX: begin
          result_r <= fix_result_s;
          rd_out_r <= rd_r;
          done_r   <= 1'b1;
          wen_r    <= (rd_r != 5'd0);
        end
        DONE: begin
          done_r <= 1'b0;
          wen_r  <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
          wen_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = (state_r != IDLE);
  assign bus.done       = done_r;
  assign bus.result     = result_r;
  assign bus.rd_out     = rd_out_r;
  assign bus.RegWEn_out = wen_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops against a
// 64-bit arithmetic reference, handshake, back-to-back and asynchronous reset scenarios.
module tb_muldiv_unit;

  logic clk;
  logic AReset;
  int   tests_run;
  int   tests_failed;

  muldiv_unit_if #(.W(32)) bus ();

  muldiv_unit #(.W(32)) dut (
    .clk    (clk),
    .AReset (AReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_f(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub, p;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 32'd0) return 32'hFFFF_FFFF; return a / b; end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 32'd0) return a; return a % b; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (f3[2] && (b == 32'd0 || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 2;
`endif
    return 34;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.funct3  = f3;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.funct3  = 3'($urandom);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
    bus.rd_in   = 5'($urandom);
  endtask

  // Counts falling edges until done (bounded); busy_ok drops if busy is ever seen low.
  task automatic wait_done(input int limit, output int cycles, output bit busy_ok);
    cycles  = 0;
    busy_ok = 1'b1;
    while (cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) break;
    end
  endtask

  task automatic test_reset();
    AReset = 1'b0;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.rs1_val = 32'd0; bus.rs2_val = 32'd0; bus.rd_in = 5'd0;
    repeat (3) @(negedge clk);
    AReset = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.busy, bus.done, bus.RegWEn_out} !== 3'b000 || bus.result !== 32'd0 || bus.rd_out !== 5'd0) begin
      tests_failed++;
      $display("FAIL reset_state: busy/done/wen=%b%b%b result=%h rd_out=%0d, expected all zero",
               bus.busy, bus.done, bus.RegWEn_out, bus.result, bus.rd_out);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  f3 [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] av [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int cycles;
    bit busy_ok;
    for (int i = 0; i < 12; i++) begin
      logic [4:0] rd;
      rd = (i == 0) ? 5'd5 : 5'(i + 1);
      issue(f3[i], av[i], bv[i], rd);
      wait_done(40, cycles, busy_ok);
      tests_run++;
      if (bus.result !== ev[i] || cycles !== exp_lat(f3[i], av[i], bv[i]) || !busy_ok ||
          bus.rd_out !== rd || bus.RegWEn_out !== 1'b1) begin
        tests_failed++;
        $display("FAIL directed[%0d]: result=%h lat=%0d busy_ok=%0d rd_out=%0d wen=%b, expected result=%h lat=%0d busy_ok=1 rd_out=%0d wen=1",
                 i, bus.result, cycles, busy_ok, bus.rd_out, bus.RegWEn_out, ev[i], exp_lat(f3[i], av[i], bv[i]), rd);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed_release[%0d]: busy=%b done=%b, expected 0 0", i, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_random();
    int cycles;
    bit busy_ok;
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b, e;
      logic [4:0]  rd;
      f3 = 3'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      rd = 5'($urandom);
      e  = ref_f(f3, a, b);
      issue(f3, a, b, rd);
      wait_done(40, cycles, busy_ok);
      tests_run++;
      if (bus.result !== e || cycles !== exp_lat(f3, a, b) || bus.rd_out !== rd ||
          bus.RegWEn_out !== (rd != 5'd0)) begin
        tests_failed++;
        $display("FAIL random[%0d] f3=%0d a=%h b=%h: result=%h lat=%0d rd_out=%0d wen=%b, expected %h lat=%0d rd_out=%0d",
                 i, f3, a, b, bus.result, cycles, bus.rd_out, bus.RegWEn_out, e, exp_lat(f3, a, b), rd);
      end
    end
  endtask

  task automatic test_ignore_start();
    int cycles;
    bit busy_ok;
    issue(3'd5, 32'd1000, 32'd7, 5'd12);
    repeat (5) @(negedge clk);
    bus.funct3 = 3'd0; bus.rs1_val = 32'd3; bus.rs2_val = 32'd3; bus.rd_in = 5'd4; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(40, cycles, busy_ok);
    tests_run++;
    if (bus.result !== 32'd142 || bus.rd_out !== 5'd12 || cycles !== 29) begin
      tests_failed++;
      $display("FAIL ignore_start: result=%h rd_out=%0d lat=%0d, expected 0000008e rd_out=12 lat=29",
               bus.result, bus.rd_out, cycles);
    end
  endtask

  task automatic test_rd_zero();
    int cycles;
    bit busy_ok;
    issue(3'd0, 32'd3, 32'd4, 5'd0);
    wait_done(40, cycles, busy_ok);
    tests_run++;
    if (bus.done !== 1'b1 || bus.RegWEn_out !== 1'b0 || bus.result !== 32'd12) begin
      tests_failed++;
      $display("FAIL rd_zero: done=%b wen=%b result=%h, expected done=1 wen=0 result=0000000c",
               bus.done, bus.RegWEn_out, bus.result);
    end
  endtask

  task automatic test_reset_midcalc();
    int cycles;
    bit busy_ok;
    bit saw_done;
    issue(3'd5, 32'd1000, 32'd3, 5'd9);
    repeat (10) @(posedge clk);
    #2;
    AReset = 1'b0;
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0 || bus.RegWEn_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midcalc: busy=%b done=%b wen=%b result=%h, expected 0 0 0 00000000",
               bus.busy, bus.done, bus.RegWEn_out, bus.result);
    end
    @(negedge clk);
    AReset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.RegWEn_out) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_done: saw done=%b, expected 0", saw_done);
    end
    issue(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd3);
    wait_done(40, cycles, busy_ok);
    tests_run++;
    if (bus.result !== 32'hFFFF_FFF2 || cycles !== 34 || bus.RegWEn_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_reset_op: result=%h lat=%0d wen=%b, expected fffffff2 lat=34 wen=1",
               bus.result, cycles, bus.RegWEn_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1, r2;
    int n, n1, n2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    n1 = -1; n2 = -1; r1 = 32'd0; r2 = 32'd0;
    @(negedge clk);
    bus.funct3 = 3'd3; bus.rs1_val = a1; bus.rs2_val = b1; bus.rd_in = 5'd1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.funct3 = 3'd2; bus.rs1_val = a2; bus.rs2_val = b2; bus.rd_in = 5'd2;
    n = 0;
    while (n < 100 && n2 < 0) begin
      @(negedge clk);
      n++;
      if (bus.done) begin
        if (n1 < 0) begin n1 = n; r1 = bus.result; end
        else        begin n2 = n; r2 = bus.result; end
      end
    end
    bus.start = 1'b0;
    tests_run++;
    if (n1 !== 34 || n2 !== 69 || r1 !== ref_f(3'd3, a1, b1) || r2 !== ref_f(3'd2, a2, b2)) begin
      tests_failed++;
      $display("FAIL back_to_back: done at %0d/%0d results %h/%h, expected 34/69 %h/%h",
               n1, n2, r1, r2, ref_f(3'd3, a1, b1), ref_f(3'd2, a2, b2));
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_rd_zero();
    test_reset_midcalc();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
